// File: rtl/tx.sv
// tx: UART transmitter, 8 data bits LSB first, odd parity, one stop bit, Send/Sent handshake.
module tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sout,
  output logic       Sent,
  output logic       Busy
);
  localparam int BAUD_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int TW = BAUD_CYCLES > 1 ? $clog2(BAUD_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, START, BITS, PAR, STOP, ACK} state_t;
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    cnt_q;
  logic [8:0]    shreg_q;
  logic          sout_q;
  logic          timer_done;
  assign timer_done = timer_q == TW'(BAUD_CYCLES - 1);
  assign Sout = sout_q;
  assign Sent = state_q == ACK;
  assign Busy = state_q != IDLE && state_q != ACK;
  // every state change in START..STOP coincides with timer_done, so wrapping also clears on change
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sout_q  <= 1'b1;
      timer_q <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      timer_q <= (timer_done || !Busy) ? '0 : timer_q + 1'b1;
      case (state_q)
        IDLE: if (Send) begin
          shreg_q <= {~^Din, Din};
          cnt_q   <= '0;
          sout_q  <= 1'b0;
          state_q <= START;
        end
        START: if (timer_done) begin
          sout_q  <= shreg_q[0];
          state_q <= BITS;
        end
        BITS: if (timer_done) begin
          shreg_q <= shreg_q >> 1;
          sout_q  <= shreg_q[1];
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= PAR;
        end
        PAR: if (timer_done) begin
          sout_q  <= 1'b1;
          state_q <= STOP;
        end
        STOP: if (timer_done) state_q <= ACK;
        ACK: if (!Send) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx.sv
// tb_tx: table-driven, directed and random frame checks of tx against a frame-level model.
module tb_tx;
  localparam int B  = 10;
  localparam int B1 = 100_000_000 / 19_200;
  logic clk = 1'b0, rst = 1'b1;
  logic send0 = 1'b0, send1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic sout0, sent0, busy0, sout1, sent1, busy1;
  int n_chk = 0, n_fail = 0;
  tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100)) u0 (
    .clk(clk), .rst(rst), .Send(send0), .Din(din0), .Sout(sout0), .Sent(sent0), .Busy(busy0)
  );
  tx u1 (
    .clk(clk), .rst(rst), .Send(send1), .Din(din1), .Sout(sout1), .Sent(sent1), .Busy(busy1)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] din; logic par; int drop_at;} vec_t;
  vec_t tbl[7];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // frame line level k (0=start, 1..8 data LSB first, 9 parity, 10 stop)
  function automatic logic model_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ($countones(d) % 2) == 0;
    return 1'b1;
  endfunction
  // accept d, follow all 11 bit periods cycle by cycle, end sampled in ACK
  task automatic run_frame(input logic [7:0] d, input logic exp_par, input int drop_at);
    logic [10:0] rx;
    din0 = d;
    send0 = 1'b1;
    step();
    for (int j = 0; j < 11 * B; j++) begin
      check("sout", sout0, model_bit(d, j / B));
      check("busy", busy0, 1'b1);
      check("sent_early", sent0, 1'b0);
      if (j % B == B / 2) rx[j / B] = sout0;
      if (j == drop_at) begin
        send0 = 1'b0;
        din0 = 8'hAA;
      end
      step();
    end
    check("sent_ack", sent0, 1'b1);
    check("busy_ack", busy0, 1'b0);
    check("sout_ack", sout0, 1'b1);
    check("decoded_data", rx[8:1], d);
    check("parity_bit", rx[9], exp_par);
    check("odd_total", 8'($countones(rx[9:1]) % 2), 8'd1);
  endtask
  task automatic finish_ack();
    send0 = 1'b0;
    step();
    check("sent_drop", sent0, 1'b0);
    check("busy_idle", busy0, 1'b0);
  endtask
  initial begin
    logic [10:0] rx1;
    logic [7:0] d;
    int drop;
    tbl[0] = '{8'h41, 1'b1, -1};
    tbl[1] = '{8'h07, 1'b0, -1};
    tbl[2] = '{8'h00, 1'b1, -1};
    tbl[3] = '{8'hFF, 1'b1, -1};
    tbl[4] = '{8'h80, 1'b0, 3};
    tbl[5] = '{8'hC3, 1'b1, 95};
    tbl[6] = '{8'h01, 1'b0, 0};
    step();
    step();
    check("rst_sout", sout0, 1'b1);
    check("rst_sent", sent0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    rst = 1'b0;
    step();
    check("idle_sout", sout0, 1'b1);
    // 0x41 then Send held long after Sent: no retransmit
    run_frame(8'h41, 1'b1, -1);
    for (int i = 0; i < 300; i++) begin
      step();
      check("hold_sent", sent0, 1'b1);
      check("hold_sout", sout0, 1'b1);
      check("hold_busy", busy0, 1'b0);
    end
    finish_ack();
    step();
    check("idle_after_hold", sout0, 1'b1);
    check("idle_after_hold_busy", busy0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].din, tbl[i].par, tbl[i].drop_at);
      finish_ack();
    end
    // Send dropped and Din changed mid-frame, then immediate re-request
    run_frame(8'h55, 1'b1, 4 * B + 2);
    step();
    check("sent_pulse", sent0, 1'b0);
    run_frame(8'h5A, 1'b1, -1);
    finish_ack();
    // reset during 4th data bit, then Send on the first cycle after reset
    din0 = 8'h99;
    send0 = 1'b1;
    step();
    for (int j = 0; j < 4 * B + 3; j++) step();
    check("pre_rst_busy", busy0, 1'b1);
    rst = 1'b1;
    send0 = 1'b0;
    step();
    check("abort_sout", sout0, 1'b1);
    check("abort_busy", busy0, 1'b0);
    check("abort_sent", sent0, 1'b0);
    rst = 1'b0;
    run_frame(8'h3C, 1'b1, -1);
    finish_ack();
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11 * B - 1)) : -1;
      run_frame(d, ($countones(d) % 2) == 0, drop);
      finish_ack();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step();
        check("gap_sout", sout0, 1'b1);
      end
    end
    // default baud rate, boundaries and loopback decode
    din1 = 8'hA5;
    send1 = 1'b1;
    step();
    for (int j = 0; j < 11 * B1; j++) begin
      if (j % B1 == 0 || j % B1 == B1 - 1) check("def_sout", sout1, model_bit(8'hA5, j / B1));
      if (j % B1 == B1 / 2) rx1[j / B1] = sout1;
      if (j == 11 * B1 - 1) begin
        check("def_sent_early", sent1, 1'b0);
        check("def_busy", busy1, 1'b1);
      end
      step();
    end
    check("def_sent", sent1, 1'b1);
    check("def_busy_ack", busy1, 1'b0);
    check("loop_dout", rx1[8:1], 8'hA5);
    check("loop_parity_err", 8'($countones(rx1[9:1]) % 2 == 0), 8'd0);
    send1 = 1'b0;
    step();
    check("def_sent_drop", sent1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx.md
Name: tx

Overview:
UART transmitter. Serializes one 8-bit byte per request: start bit, 8 data bits LSB first, odd parity bit, stop bit, at BAUD_RATE. It sits between the host logic and the serial TX pin. It is the transmit-side counterpart of the team's odd-parity 19200-baud UART receiver, and uses a four-phase Send/Sent handshake.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock frequency in Hz
BAUD_RATE, 19_200, serial bit rate in bits/s; bit period BAUD_CYCLES = CLK_FREQUENCY / BAUD_RATE (integer division, 5208 at defaults)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
Send  input  1  host request to transmit Din; held high until Sent observed
Din  input  8  byte to transmit; sampled only on the accepting cycle
Sout  output  1  serial output line, idle high
Sent  output  1  frame fully transmitted (stop bit complete); held until Send drops
Busy  output  1  high while a frame is on the line (START through STOP)

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. While rst=1 at a posedge: state=IDLE, Sout=1, Sent=0, Busy=0, baud timer=0, bit counter=0. Reset mid-frame aborts the frame; Sout returns to 1 at that edge. There is no partial completion and Sent is not asserted.
- Sout is driven from a flop (glitch-free). Sent and Busy are decoded from state.
- Baud timer: counts 0..BAUD_CYCLES-1 and wraps. It is cleared on frame start and on each state change. timerDone = (timer == BAUD_CYCLES-1).
- Shift register: 9 bits {parity, Din}. It loads on accept, with parity = ~^Din (total ones in data+parity is odd). It shifts right on each data-bit boundary.
- States: IDLE, START, BITS, PAR, STOP, ACK.
- IDLE: Sout=1. If Send=1, then at that edge: latch Din and parity, clear the timer and bit counter, and go to START. Sout=0 from the next cycle.
- START: Sout=0 for exactly BAUD_CYCLES cycles. On timerDone, go to BITS and drive Din[0].
- BITS: each data bit is held BAUD_CYCLES cycles, LSB first. On timerDone with bit counter < 7, shift and increment. On timerDone with counter = 7, go to PAR.
- PAR: Sout=parity bit for BAUD_CYCLES cycles. On timerDone, go to STOP.
- STOP: Sout=1 for BAUD_CYCLES cycles. On timerDone, go to ACK.
- ACK: Sout=1, Sent=1. Stay while Send=1. When Send=0, go to IDLE; Sent drops the same edge.
- Timing: from the accepting edge to entering ACK is exactly 11*BAUD_CYCLES cycles. The first start-bit cycle is the cycle after the accept edge.
- Busy=1 in START, BITS, PAR and STOP; 0 in IDLE and ACK.
- Din changes after accept are ignored for the whole frame.
- Send dropping mid-frame does not abort; the frame completes, and ACK exits at its first cycle if Send is already 0.
- Send held high continuously: exactly one frame, then ACK holds. No retransmit until Send goes 0 then 1.
- Back-to-back: the minimum gap between frames is one IDLE cycle (ACK→IDLE, then accept).
- Send=1 on the first cycle after reset is accepted normally.

Test Plan:
1. CLK_FREQUENCY=1000, BAUD_RATE=100 (10 cycles/bit); Send=1, Din=8'h41 → Sout holds each of 0, 1,0,0,0,0,0,1,0, 1 (parity), 1 (stop) for 10 cycles. Sent=1 exactly 110 cycles after the accept edge. Busy=1 for those 110 cycles.
2. Din=8'h07 → parity bit 0. Din=8'h00 → parity bit 1. Din=8'hFF → parity bit 1. A monitor decodes each frame, matches the data, and confirms odd total parity.
3. Hold Send=1 for 300 cycles after Sent → Sent stays 1, Sout stays 1, no second start bit. Drop Send → Sent=0 next edge, state IDLE.
4. Drop Send and change Din to 8'hAA during BITS of an 8'h55 frame → the full 8'h55 frame is transmitted, then Sent pulses for 1 cycle. Reassert Send → the next frame starts after 1 IDLE cycle.
5. Assert rst=1 for 1 cycle during the 4th data bit → Sout=1, Busy=0, Sent=0 after that edge. A subsequent Send with 8'h3C transmits a correct full frame.
6. Default parameters (5208 cycles/bit) with Din=8'hA5 → each bit lasts 5208 cycles and Sent asserts 57288 cycles after accept. A loopback through the team's receiver yields Dout=8'hA5 and parityErr=0.
